// File: rtl/ipm2t_hssthp_hpll_lock_supervisor.sv
// HSSTHP HPLL lock supervisor.
// Holds the HPLL reset FSM in reset for a fixed pulse, waits for its done flag,
// then watches the synchronized lock indicator. A filtered loss of lock or a
// done timeout is a failed attempt that re-runs bring-up, up to MAX_RETRY times.
module ipm2t_hssthp_hpll_lock_supervisor #(
  parameter int unsigned FREE_CLOCK_FREQ     = 100,
  parameter int unsigned RST_PULSE_CYCLES    = FREE_CLOCK_FREQ,
  parameter int unsigned LOCK_FILTER_CYCLES  = 2 * FREE_CLOCK_FREQ,
  parameter int unsigned DONE_TIMEOUT_CYCLES = 50 * FREE_CLOCK_FREQ,
  parameter int unsigned MAX_RETRY           = 3,
  parameter int unsigned CNTR_WIDTH          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       hpll_done,
  input  logic       force_recal,
  output logic       o_hpll_fsm_rst_n,
  output logic       o_hpll_ready,
  output logic       o_lol_event,
  output logic [1:0] o_retry_cnt,
  output logic       o_hpll_fail
);

  typedef enum logic [2:0] {
    StReset    = 3'd0,
    StWaitDone = 3'd1,
    StRun      = 3'd2,
    StLolFilt  = 3'd3,
    StFail     = 3'd4
  } state_e;

  localparam logic [CNTR_WIDTH-1:0] RstLast  = CNTR_WIDTH'(RST_PULSE_CYCLES - 1);
  localparam logic [CNTR_WIDTH-1:0] DoneLast = CNTR_WIDTH'(DONE_TIMEOUT_CYCLES - 1);
  // The first low lock sample is taken in StRun, so the filter state needs one fewer.
  localparam logic [CNTR_WIDTH-1:0] FiltLast = CNTR_WIDTH'(LOCK_FILTER_CYCLES - 2);
  localparam logic [CNTR_WIDTH-1:0] TimerMax = {CNTR_WIDTH{1'b1}};
  localparam logic [1:0]            RetryMax = 2'(MAX_RETRY);

  state_e                state;
  logic [CNTR_WIDTH-1:0] timer;
  logic                  lock_meta;
  logic                  lock_s;
  logic                  retry_exhausted;

  assign retry_exhausted = (o_retry_cnt == RetryMax);

  // Lock synchronizer, bring-up FSM, timer and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= StReset;
      timer            <= '0;
      lock_meta        <= 1'b0;
      lock_s           <= 1'b0;
      o_hpll_fsm_rst_n <= 1'b0;
      o_hpll_ready     <= 1'b0;
      o_lol_event      <= 1'b0;
      o_retry_cnt      <= 2'd0;
      o_hpll_fail      <= 1'b0;
    end else begin
      lock_meta   <= pll_lock;
      lock_s      <= lock_meta;
      o_lol_event <= 1'b0;
      if (timer != TimerMax) begin
        timer <= timer + CNTR_WIDTH'(1);
      end

      if (force_recal && (state != StReset)) begin
        // Manual restart: wipes the retry history and any sticky failure.
        state            <= StReset;
        timer            <= '0;
        o_retry_cnt      <= 2'd0;
        o_hpll_fail      <= 1'b0;
        o_hpll_fsm_rst_n <= 1'b0;
        o_hpll_ready     <= 1'b0;
      end else begin
        case (state)
          StReset: begin
            if (timer == RstLast) begin
              state            <= StWaitDone;
              timer            <= '0;
              o_hpll_fsm_rst_n <= 1'b1;
            end
          end

          StWaitDone: begin
            if (hpll_done) begin
              state        <= StRun;
              timer        <= '0;
              o_hpll_ready <= 1'b1;
              o_retry_cnt  <= 2'd0;
            end else if (timer == DoneLast) begin
              timer            <= '0;
              o_hpll_fsm_rst_n <= 1'b0;
              o_hpll_ready     <= 1'b0;
              if (retry_exhausted) begin
                state       <= StFail;
                o_hpll_fail <= 1'b1;
              end else begin
                state       <= StReset;
                o_retry_cnt <= o_retry_cnt + 2'd1;
              end
            end
          end

          StRun: begin
            if (!lock_s) begin
              state <= StLolFilt;
              timer <= '0;
            end else if (!hpll_done) begin
              // HPLL FSM dropped done on its own: wait again, not a retry.
              state        <= StWaitDone;
              timer        <= '0;
              o_hpll_ready <= 1'b0;
            end
          end

          StLolFilt: begin
            if (lock_s) begin
              state <= StRun;
              timer <= '0;
            end else if (timer == FiltLast) begin
              // Expiry outranks a falling done so the LOL is always reported.
              o_lol_event      <= 1'b1;
              timer            <= '0;
              o_hpll_fsm_rst_n <= 1'b0;
              o_hpll_ready     <= 1'b0;
              if (retry_exhausted) begin
                state       <= StFail;
                o_hpll_fail <= 1'b1;
              end else begin
                state       <= StReset;
                o_retry_cnt <= o_retry_cnt + 2'd1;
              end
            end else if (!hpll_done) begin
              state        <= StWaitDone;
              timer        <= '0;
              o_hpll_ready <= 1'b0;
            end
          end

          StFail: begin
            o_hpll_fsm_rst_n <= 1'b0;
            o_hpll_ready     <= 1'b0;
          end

          default: begin
            state            <= StReset;
            timer            <= '0;
            o_hpll_fsm_rst_n <= 1'b0;
            o_hpll_ready     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ipm2t_hssthp_hpll_lock_supervisor.sv
// Directed bench for the HPLL lock supervisor with default parameters
// (reset pulse 100, lock filter 200, done timeout 5000, max retry 3).
module tb_ipm2t_hssthp_hpll_lock_supervisor;

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       hpll_done;
  logic       force_recal;
  logic       o_hpll_fsm_rst_n;
  logic       o_hpll_ready;
  logic       o_lol_event;
  logic [1:0] o_retry_cnt;
  logic       o_hpll_fail;

  int checks = 0;
  int errors = 0;

  ipm2t_hssthp_hpll_lock_supervisor dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pll_lock         (pll_lock),
    .hpll_done        (hpll_done),
    .force_recal      (force_recal),
    .o_hpll_fsm_rst_n (o_hpll_fsm_rst_n),
    .o_hpll_ready     (o_hpll_ready),
    .o_lol_event      (o_lol_event),
    .o_retry_cnt      (o_retry_cnt),
    .o_hpll_fail      (o_hpll_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive and sample 1 ns after each rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic saw_event;
    logic saw_not_ready;

    rst_n       = 1'b0;
    pll_lock    = 1'b1;
    hpll_done   = 1'b0;
    force_recal = 1'b0;
    tick(3);
    chk("rst_fsm_rst_n", 32'(o_hpll_fsm_rst_n), 32'd0);
    chk("rst_ready", 32'(o_hpll_ready), 32'd0);
    chk("rst_lol", 32'(o_lol_event), 32'd0);
    chk("rst_retry", 32'(o_retry_cnt), 32'd0);
    chk("rst_fail", 32'(o_hpll_fail), 32'd0);

    // Bring-up: reset pulse of exactly 100 clocks, done 300 clocks later.
    rst_n = 1'b1;
    tick(99);
    chk("bring_pulse_low99", 32'(o_hpll_fsm_rst_n), 32'd0);
    tick(1);
    chk("bring_pulse_rise100", 32'(o_hpll_fsm_rst_n), 32'd1);
    tick(300);
    chk("bring_not_ready", 32'(o_hpll_ready), 32'd0);
    hpll_done = 1'b1;
    tick(1);
    chk("bring_ready", 32'(o_hpll_ready), 32'd1);
    chk("bring_retry", 32'(o_retry_cnt), 32'd0);

    // Lock glitch of 150 clocks is absorbed.
    pll_lock      = 1'b0;
    saw_event     = 1'b0;
    saw_not_ready = 1'b0;
    for (int i = 0; i < 160; i++) begin
      if (i == 150) pll_lock = 1'b1;
      tick(1);
      saw_event     = saw_event | o_lol_event;
      saw_not_ready = saw_not_ready | ~o_hpll_ready;
    end
    chk("glitch_no_event", 32'(saw_event), 32'd0);
    chk("glitch_ready_held", 32'(saw_not_ready), 32'd0);

    // True LOL: event 202 clocks after the drop, then retry and new pulse.
    pll_lock = 1'b0;
    tick(201);
    chk("lol_event_early", 32'(o_lol_event), 32'd0);
    chk("lol_ready_filtering", 32'(o_hpll_ready), 32'd1);
    tick(1);
    chk("lol_event", 32'(o_lol_event), 32'd1);
    chk("lol_ready_drop", 32'(o_hpll_ready), 32'd0);
    chk("lol_retry", 32'(o_retry_cnt), 32'd1);
    chk("lol_fsm_rst_n", 32'(o_hpll_fsm_rst_n), 32'd0);
    hpll_done = 1'b0;
    pll_lock  = 1'b1;
    tick(1);
    chk("lol_event_one_cycle", 32'(o_lol_event), 32'd0);
    tick(98);
    chk("lol_pulse_low", 32'(o_hpll_fsm_rst_n), 32'd0);
    tick(1);
    chk("lol_pulse_rise", 32'(o_hpll_fsm_rst_n), 32'd1);
    tick(10);
    hpll_done = 1'b1;
    tick(1);
    chk("relock_ready", 32'(o_hpll_ready), 32'd1);
    chk("relock_retry_clear", 32'(o_retry_cnt), 32'd0);

    // force_recal on the LOL filter expiry edge suppresses the event.
    pll_lock = 1'b0;
    tick(201);
    force_recal = 1'b1;
    tick(1);
    force_recal = 1'b0;
    pll_lock    = 1'b1;
    hpll_done   = 1'b0;
    chk("prio_no_event", 32'(o_lol_event), 32'd0);
    chk("prio_retry", 32'(o_retry_cnt), 32'd0);
    chk("prio_fsm_rst_n", 32'(o_hpll_fsm_rst_n), 32'd0);
    chk("prio_ready", 32'(o_hpll_ready), 32'd0);

    // Exhaustion: four done timeouts, retry 1,2,3 then sticky fail.
    for (int i = 1; i <= 4; i++) begin
      tick(99);
      chk($sformatf("exh%0d_pulse_low", i), 32'(o_hpll_fsm_rst_n), 32'd0);
      tick(1);
      chk($sformatf("exh%0d_pulse_rise", i), 32'(o_hpll_fsm_rst_n), 32'd1);
      tick(4999);
      chk($sformatf("exh%0d_retry_before", i), 32'(o_retry_cnt), 32'(i - 1));
      chk($sformatf("exh%0d_fail_before", i), 32'(o_hpll_fail), 32'd0);
      tick(1);
      chk($sformatf("exh%0d_retry_after", i), 32'(o_retry_cnt), 32'((i > 3) ? 3 : i));
      chk($sformatf("exh%0d_fail_after", i), 32'(o_hpll_fail), 32'((i == 4) ? 1 : 0));
      chk($sformatf("exh%0d_fsm_rst_n", i), 32'(o_hpll_fsm_rst_n), 32'd0);
    end
    tick(200);
    chk("fail_sticky", 32'(o_hpll_fail), 32'd1);
    chk("fail_fsm_rst_n_held", 32'(o_hpll_fsm_rst_n), 32'd0);

    // Recovery from FAIL via force_recal.
    force_recal = 1'b1;
    tick(1);
    force_recal = 1'b0;
    chk("recal_fail_clear", 32'(o_hpll_fail), 32'd0);
    chk("recal_retry_clear", 32'(o_retry_cnt), 32'd0);
    chk("recal_fsm_rst_n", 32'(o_hpll_fsm_rst_n), 32'd0);
    tick(99);
    chk("recal_pulse_low", 32'(o_hpll_fsm_rst_n), 32'd0);
    tick(1);
    chk("recal_pulse_rise", 32'(o_hpll_fsm_rst_n), 32'd1);
    tick(5);
    hpll_done = 1'b1;
    tick(1);
    chk("recal_ready", 32'(o_hpll_ready), 32'd1);

    // Reset mid-operation while filtering a lock loss.
    pll_lock = 1'b0;
    tick(50);
    chk("midop_ready_filtering", 32'(o_hpll_ready), 32'd1);
    rst_n = 1'b0;
    tick(1);
    chk("midop_fsm_rst_n", 32'(o_hpll_fsm_rst_n), 32'd0);
    chk("midop_ready", 32'(o_hpll_ready), 32'd0);
    chk("midop_lol", 32'(o_lol_event), 32'd0);
    chk("midop_retry", 32'(o_retry_cnt), 32'd0);
    chk("midop_fail", 32'(o_hpll_fail), 32'd0);
    rst_n     = 1'b1;
    pll_lock  = 1'b1;
    hpll_done = 1'b0;
    tick(99);
    chk("midop_pulse_low", 32'(o_hpll_fsm_rst_n), 32'd0);
    tick(1);
    chk("midop_pulse_rise", 32'(o_hpll_fsm_rst_n), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
